// File: rtl/mshr_alloc_ctrl.sv
// rtl/mshr_alloc_ctrl.sv - MSHR entry allocator offering two free entries per cycle
//
// Purpose: tracks which MSHR entries are busy, offers the two lowest-numbered
// free entries to the request arbiter, and accepts up to two releases per cycle.
//
// Ports:
//   clk               single clock, rising edge
//   rst_n             synchronous reset, active-high (1 = reset)
//   mshr_alloc_vld    two free entries are on offer (free_cnt >= 2)
//   mshr_alloc_idx_1  lowest-numbered free entry (0 when not valid)
//   mshr_alloc_idx_2  second-lowest-numbered free entry (0 when not valid)
//   mshr_alloc_rdy    arbiter takes the offer
//   mshr_alloc_use_2  arbiter also takes idx_2 on this handshake
//   rel_vld_1/2       release strobes
//   rel_idx_1/2       entries being released
//   free_cnt          number of free entries
//   mshr_full         no free entries
//   rel_err           sticky flag for illegal releases

module mshr_alloc_ctrl #(
    parameter int ENTRY_NUM       = 16,
    parameter int ENTRY_IDX_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               mshr_alloc_vld,
    output logic [ENTRY_IDX_WIDTH-1:0]         mshr_alloc_idx_1,
    output logic [ENTRY_IDX_WIDTH-1:0]         mshr_alloc_idx_2,
    input  logic                               mshr_alloc_rdy,
    input  logic                               mshr_alloc_use_2,
    input  logic                               rel_vld_1,
    input  logic                               rel_vld_2,
    input  logic [ENTRY_IDX_WIDTH-1:0]         rel_idx_1,
    input  logic [ENTRY_IDX_WIDTH-1:0]         rel_idx_2,
    output logic [$clog2(ENTRY_NUM+1)-1:0]     free_cnt,
    output logic                               mshr_full,
    output logic                               rel_err
);

    localparam int CNT_W = $clog2(ENTRY_NUM + 1);

    logic [ENTRY_NUM-1:0]       busy;
    logic [ENTRY_NUM-1:0]       busy_nxt;
    logic [ENTRY_IDX_WIDTH-1:0] first_idx;
    logic [ENTRY_IDX_WIDTH-1:0] second_idx;
    logic                       found_1;
    logic                       found_2;
    logic                       handshake;
    logic                       hit_1;
    logic                       hit_2;
    logic                       dup_rel;
    logic                       rel_ok_1;
    logic                       rel_ok_2;
    logic                       rel_bad;
    logic [CNT_W-1:0]           n_rel;
    logic [CNT_W-1:0]           n_alloc;

    // Priority search for the first two zero bits, low index first.
    always_comb begin
        first_idx  = '0;
        second_idx = '0;
        found_1    = 1'b0;
        found_2    = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!busy[i]) begin
                if (!found_1) begin
                    first_idx = ENTRY_IDX_WIDTH'(i);
                    found_1   = 1'b1;
                end else if (!found_2) begin
                    second_idx = ENTRY_IDX_WIDTH'(i);
                    found_2    = 1'b1;
                end
            end
        end
    end

    assign mshr_alloc_vld   = (free_cnt >= CNT_W'(2));
    assign mshr_alloc_idx_1 = mshr_alloc_vld ? first_idx  : '0;
    assign mshr_alloc_idx_2 = mshr_alloc_vld ? second_idx : '0;
    assign mshr_full        = (free_cnt == '0);
    assign handshake        = mshr_alloc_vld && mshr_alloc_rdy;

    // A release only counts if it names an in-range entry that is currently busy.
    // When both ports name the same entry, port 1 frees it and port 2 is the error.
    assign hit_1    = (int'(rel_idx_1) < ENTRY_NUM) && busy[rel_idx_1];
    assign hit_2    = (int'(rel_idx_2) < ENTRY_NUM) && busy[rel_idx_2];
    assign dup_rel  = rel_vld_1 && rel_vld_2 && (rel_idx_1 == rel_idx_2);
    assign rel_ok_1 = rel_vld_1 && hit_1;
    assign rel_ok_2 = rel_vld_2 && hit_2 && !dup_rel;
    assign rel_bad  = (rel_vld_1 && !hit_1) || (rel_vld_2 && (!hit_2 || dup_rel));

    // Releases only touch busy bits and allocations only touch free bits, so the
    // two update sets never overlap and their order here does not matter.
    always_comb begin
        busy_nxt = busy;
        n_rel    = '0;
        n_alloc  = '0;
        if (rel_ok_1) begin
            busy_nxt[rel_idx_1] = 1'b0;
            n_rel               = n_rel + CNT_W'(1);
        end
        if (rel_ok_2) begin
            busy_nxt[rel_idx_2] = 1'b0;
            n_rel               = n_rel + CNT_W'(1);
        end
        if (handshake) begin
            busy_nxt[first_idx] = 1'b1;
            n_alloc             = CNT_W'(1);
            if (mshr_alloc_use_2) begin
                busy_nxt[second_idx] = 1'b1;
                n_alloc              = CNT_W'(2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy     <= '0;
            free_cnt <= CNT_W'(ENTRY_NUM);
            rel_err  <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            free_cnt <= free_cnt + n_rel - n_alloc;
            if (rel_bad) begin
                rel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mshr_alloc_ctrl.sv
// tb/tb_mshr_alloc_ctrl.sv - scoreboard testbench for mshr_alloc_ctrl

module tb_mshr_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mshr_alloc_vld;
    logic [3:0] mshr_alloc_idx_1;
    logic [3:0] mshr_alloc_idx_2;
    logic       mshr_alloc_rdy;
    logic       mshr_alloc_use_2;
    logic       rel_vld_1;
    logic       rel_vld_2;
    logic [3:0] rel_idx_1;
    logic [3:0] rel_idx_2;
    logic [4:0] free_cnt;
    logic       mshr_full;
    logic       rel_err;

    int checks   = 0;
    int failures = 0;

    // Observation layout: {vld, idx_1, idx_2, free_cnt, full, rel_err}
    logic [15:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        use2;
        logic        rv1;
        logic [3:0]  ri1;
        logic        rv2;
        logic [3:0]  ri2;
        logic [15:0] want;
    } step_t;

    mshr_alloc_ctrl #(.ENTRY_NUM(16), .ENTRY_IDX_WIDTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mshr_alloc_vld   (mshr_alloc_vld),
        .mshr_alloc_idx_1 (mshr_alloc_idx_1),
        .mshr_alloc_idx_2 (mshr_alloc_idx_2),
        .mshr_alloc_rdy   (mshr_alloc_rdy),
        .mshr_alloc_use_2 (mshr_alloc_use_2),
        .rel_vld_1        (rel_vld_1),
        .rel_vld_2        (rel_vld_2),
        .rel_idx_1        (rel_idx_1),
        .rel_idx_2        (rel_idx_2),
        .free_cnt         (free_cnt),
        .mshr_full        (mshr_full),
        .rel_err          (rel_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input int v, input int i1, input int i2, input int c, input int e);
        logic [31:0] a, b, n;
        a = i1; b = i2; n = c;
        return {v[0], a[3:0], b[3:0], n[4:0], (c == 0), e[0]};
    endfunction

    function automatic logic [15:0] obs();
        return {mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2, free_cnt, mshr_full, rel_err};
    endfunction

    function automatic step_t st(input logic rst, input logic rdy, input logic use2,
                                 input logic rv1, input logic [3:0] ri1,
                                 input logic rv2, input logic [3:0] ri2, input logic [15:0] want);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.use2 = use2; s.rv1 = rv1; s.ri1 = ri1;
        s.rv2 = rv2; s.ri2 = ri2; s.want = want;
        return s;
    endfunction

    // Drive one cycle of inputs, clock it, return inputs to idle; outputs are
    // then sampled 1 time unit after the edge.
    task automatic apply(input logic rst, input logic rdy, input logic use2,
                         input logic rv1, input logic [3:0] ri1,
                         input logic rv2, input logic [3:0] ri2);
        rst_n = rst; mshr_alloc_rdy = rdy; mshr_alloc_use_2 = use2;
        rel_vld_1 = rv1; rel_idx_1 = ri1; rel_vld_2 = rv2; rel_idx_2 = ri2;
        @(posedge clk);
        #1;
        rst_n = 1'b0; mshr_alloc_rdy = 1'b0; mshr_alloc_use_2 = 1'b0;
        rel_vld_1 = 1'b0; rel_idx_1 = '0; rel_vld_2 = 1'b0; rel_idx_2 = '0;
    endtask

    task automatic test_reset();
        logic [15:0] got, want;
        exp_q.push_back(mk(1, 0, 1, 16, 0));
        apply(1, 1, 1, 1, 4'd3, 0, 0);
        got = obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset got=%h want=%h", got, want);
        end
    endtask

    task automatic test_fill();
        logic [15:0] got, want;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(k < 7, k < 7 ? 2*k+2 : 0, k < 7 ? 2*k+3 : 0, 14 - 2*k, 0));
            apply(0, 1, 1, 0, 0, 0, 0);
            got = obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL fill[%0d] got=%h want=%h", k, got, want);
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        apply(0, 1, 1, 0, 0, 0, 0);
        got = obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL rdy_while_full got=%h want=%h", got, want);
        end
    endtask

    task automatic test_release_pair();
        logic [15:0] got, want;
        exp_q.push_back(mk(1, 5, 9, 2, 0));
        apply(0, 0, 0, 1, 4'd5, 1, 4'd9);
        got = obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL release_pair got=%h want=%h", got, want);
        end
    endtask

    task automatic test_single_and_no_bypass();
        logic [15:0] got, want;
        step_t s[$];
        apply(1, 0, 0, 0, 0, 0, 0);
        s.push_back(st(0, 1, 0, 0, 4'd0, 0, 4'd0, mk(1, 1, 2, 15, 0)));
        s.push_back(st(0, 1, 0, 0, 4'd0, 0, 4'd0, mk(1, 2, 3, 14, 0)));
        foreach (s[i]) begin
            exp_q.push_back(s[i].want);
            apply(s[i].rst, s[i].rdy, s[i].use2, s[i].rv1, s[i].ri1, s[i].rv2, s[i].ri2);
            got = obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL single[%0d] got=%h want=%h", i, got, want);
            end
        end
        // Releasing entry 0 must not show up in the offer within the same cycle.
        rel_vld_1 = 1'b1; rel_idx_1 = 4'd0;
        #1;
        got = obs(); want = mk(1, 2, 3, 14, 0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL no_bypass got=%h want=%h", got, want);
        end
        exp_q.push_back(mk(1, 0, 2, 15, 0));
        apply(0, 0, 0, 1, 4'd0, 0, 0);
        got = obs(); want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL after_release got=%h want=%h", got, want);
        end
    endtask

    task automatic test_alloc_with_release();
        logic [15:0] got, want;
        step_t s[$];
        apply(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) apply(0, 1, 1, 0, 0, 0, 0);
        s.push_back(st(0, 0, 0, 1, 4'd3,  1, 4'd7, mk(1, 3, 7, 2, 0)));
        s.push_back(st(0, 1, 1, 1, 4'd12, 0, 4'd0, mk(0, 0, 0, 1, 0)));
        s.push_back(st(0, 0, 0, 1, 4'd0,  0, 4'd0, mk(1, 0, 12, 2, 0)));
        foreach (s[i]) begin
            exp_q.push_back(s[i].want);
            apply(s[i].rst, s[i].rdy, s[i].use2, s[i].rv1, s[i].ri1, s[i].rv2, s[i].ri2);
            got = obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL alloc_rel[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, want;
        step_t s[$];
        apply(1, 0, 0, 0, 0, 0, 0);
        s.push_back(st(0, 1, 1, 0, 4'd0, 0, 4'd0, mk(1, 2, 3, 14, 0)));
        s.push_back(st(0, 1, 1, 0, 4'd0, 0, 4'd0, mk(1, 4, 5, 12, 0)));
        s.push_back(st(0, 1, 1, 0, 4'd0, 0, 4'd0, mk(1, 6, 7, 10, 0)));
        s.push_back(st(0, 1, 1, 1, 4'd0, 1, 4'd2, mk(1, 0, 2, 10, 0)));
        foreach (s[i]) begin
            exp_q.push_back(s[i].want);
            apply(s[i].rst, s[i].rdy, s[i].use2, s[i].rv1, s[i].ri1, s[i].rv2, s[i].ri2);
            got = obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_rel_err();
        logic [15:0] got, want;
        step_t s[$];
        apply(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) apply(0, 1, 1, 0, 0, 0, 0);
        s.push_back(st(0, 0, 0, 1, 4'd4, 0, 4'd0, mk(1, 4, 8, 9, 0)));
        s.push_back(st(0, 0, 0, 1, 4'd4, 0, 4'd0, mk(1, 4, 8, 9, 1)));
        s.push_back(st(0, 0, 0, 1, 4'd6, 1, 4'd6, mk(1, 4, 6, 10, 1)));
        s.push_back(st(0, 0, 0, 0, 4'd0, 0, 4'd0, mk(1, 4, 6, 10, 1)));
        foreach (s[i]) begin
            exp_q.push_back(s[i].want);
            apply(s[i].rst, s[i].rdy, s[i].use2, s[i].rv1, s[i].ri1, s[i].rv2, s[i].ri2);
            got = obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rel_err[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] got, want;
        step_t s[$];
        s.push_back(st(0, 1, 1, 0, 4'd0, 0, 4'd0, mk(1, 8, 9, 8, 1)));
        s.push_back(st(0, 1, 1, 0, 4'd0, 0, 4'd0, mk(1, 10, 11, 6, 1)));
        s.push_back(st(1, 1, 1, 1, 4'd2, 1, 4'd3, mk(1, 0, 1, 16, 0)));
        foreach (s[i]) begin
            exp_q.push_back(s[i].want);
            apply(s[i].rst, s[i].rdy, s[i].use2, s[i].rv1, s[i].ri1, s[i].rv2, s[i].ri2);
            got = obs(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mid_reset[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; mshr_alloc_rdy = 1'b0; mshr_alloc_use_2 = 1'b0;
        rel_vld_1 = 1'b0; rel_idx_1 = '0; rel_vld_2 = 1'b0; rel_idx_2 = '0;
        #2;
        test_reset();
        test_fill();
        test_release_pair();
        test_single_and_no_bypass();
        test_alloc_with_release();
        test_back_to_back();
        test_rel_err();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mshr_alloc_ctrl.md
MSHR_ALLOC_CTRL -- requirements
Module: mshr_alloc_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16, number of MSHR entries (>=2).
REQ-002 SHALL have parameter ENTRY_IDX_WIDTH, default 4, entry index width, equal to $clog2(ENTRY_NUM).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-high (1 = reset).
REQ-005 SHALL have port mshr_alloc_vld  output  1  two free entry indices offered.
REQ-006 SHALL have port mshr_alloc_idx_1  output  ENTRY_IDX_WIDTH  lowest-numbered free entry.
REQ-007 SHALL have port mshr_alloc_idx_2  output  ENTRY_IDX_WIDTH  second-lowest-numbered free entry.
REQ-008 SHALL have port mshr_alloc_rdy  input  1  downstream request arbiter consumes the offer.
REQ-009 SHALL have port mshr_alloc_use_2  input  1  idx_2 also consumed on this handshake.
REQ-010 SHALL have ports rel_vld_1 / rel_vld_2  input  1 each  entry release strobes.
REQ-011 SHALL have ports rel_idx_1 / rel_idx_2  input  ENTRY_IDX_WIDTH each  indices being released.
REQ-012 SHALL have port free_cnt  output  $clog2(ENTRY_NUM+1)  number of free entries.
REQ-013 SHALL have port mshr_full  output  1  free_cnt == 0.
REQ-014 SHALL have port rel_err  output  1  sticky: release of an already-free or out-of-range entry.

Function
REQ-015 SHALL hold a registered busy bitmap busy[ENTRY_NUM-1:0]; 1 = entry allocated.
REQ-016 SHALL derive idx_1 and idx_2 combinationally from the registered bitmap: first and second zero bit, searched from bit 0 upward.
REQ-017 SHALL drive mshr_alloc_vld = 1 iff free_cnt >= 2; SHALL drive idx_1 = idx_2 = 0 when mshr_alloc_vld is 0.
REQ-018 SHALL treat handshake as mshr_alloc_vld && mshr_alloc_rdy; mshr_alloc_rdy while vld is 0 SHALL be ignored.
REQ-019 On handshake SHALL set busy[idx_1] next cycle, and SHALL set busy[idx_2] only if mshr_alloc_use_2 = 1.
REQ-020 SHALL allow a handshake every cycle (back-to-back), with the next offer reflecting the updated bitmap.
REQ-021 On rel_vld_k with busy[rel_idx_k] = 1, SHALL clear busy[rel_idx_k] next cycle.
REQ-022 A released entry SHALL NOT be offered in the same cycle as the release; it becomes offerable the cycle after (no bypass).
REQ-023 SHALL accept both release ports and an allocation in the same cycle, applying all updates in that cycle's bitmap write.
REQ-024 If rel_vld_1 and rel_vld_2 target the same index, SHALL clear it once and set rel_err.
REQ-025 Release of a free entry or index >= ENTRY_NUM SHALL leave the bitmap unchanged and set rel_err; rel_err SHALL stay 1 until reset.
REQ-026 SHALL register free_cnt as a counter updated by +releases - allocations each cycle, never below 0 or above ENTRY_NUM; it SHALL always equal the number of zero bits in busy.
REQ-027 SHALL drive mshr_full combinationally from free_cnt.
REQ-028 SHALL have 0-cycle offer latency, i.e. outputs valid in the same cycle as the bitmap state, and 1-cycle update latency.

Reset
REQ-029 While rst_n = 1 at a clock edge, SHALL clear busy to all-zero, set free_cnt = ENTRY_NUM and clear rel_err; allocations and releases in that cycle SHALL be discarded.
REQ-030 After reset SHALL present mshr_alloc_vld = 1, idx_1 = 0, idx_2 = 1, mshr_full = 0 (for ENTRY_NUM >= 2).
REQ-031 Reset asserted mid-operation, with entries busy, SHALL return all state to the REQ-029 values on the next edge.

Verification
REQ-032 Reset, then hold mshr_alloc_rdy = 1 and use_2 = 1 for 8 cycles -> offers (0,1), (2,3) ... (14,15); then vld = 0, free_cnt = 0, mshr_full = 1.
REQ-033 With all entries busy, rel_vld_1 = 1, rel_idx_1 = 5 and rel_vld_2 = 1, rel_idx_2 = 9 -> next cycle vld = 1, idx = (5,9), free_cnt = 2.
REQ-034 After reset, do one handshake with use_2 = 0 -> busy = 0x0001, next offer (1,2), free_cnt = 15.
REQ-035 With free_cnt = 2 holding entries (3,7), same cycle: handshake with use_2 = 1 and release of 12 -> next cycle free_cnt = 1, vld = 0, and entry 12 is the only free entry.
REQ-036 Release idx 4 while it is free, and separately release 6 on both ports -> bitmap unaffected by the bad release, entry 6 freed once, rel_err = 1 until reset.
REQ-037 Assert rst_n for 1 cycle with 10 entries busy -> next cycle free_cnt = 16, offer (0,1), rel_err = 0.
